// File: rtl/shifter_seq.sv
// Iterative shifter: one bit position per clock, start/busy/done handshake.
// Define SHIFTER_ROTATE_EN to make F==2 rotate-left instead of pass.
module shifter_seq #(
   parameter int N = 4
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            start,
   input  logic [2**N-1:0] A,
   input  logic [N-1:0]    Sh,
   input  logic [1:0]      F,
   output logic [2**N-1:0] Y,
   output logic            busy,
   output logic            done
);

   localparam int W = 2**N;

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_SHIFT = 2'd1;
   localparam logic [1:0] S_DONE  = 2'd2;

   logic [1:0]   state_q, state_d;
   logic [W-1:0] r_q, r_d;
   logic [N-1:0] cnt_q, cnt_d;
   logic [1:0]   f_q, f_d;
   logic [W-1:0] y_q, y_d;
   logic         busy_q, busy_d;
   logic         done_q, done_d;
   logic [W-1:0] step;
   logic         skip;

   // Zero shifts (and pass, when rotate is off) finish without shifting
`ifdef SHIFTER_ROTATE_EN
   assign skip = (Sh == '0);
`else
   assign skip = (Sh == '0) || (F == 2'd2);
`endif

   always_comb begin
      step = r_q;
      case (f_q)
         2'd0: step = {r_q[W-2:0], 1'b0};
         2'd1: step = {1'b0, r_q[W-1:1]};
`ifdef SHIFTER_ROTATE_EN
         2'd2: step = {r_q[W-2:0], r_q[W-1]};
`else
         2'd2: step = r_q;
`endif
         2'd3: step = {r_q[W-1], r_q[W-1:1]};
         default: step = r_q;
      endcase
   end

   always_comb begin
      state_d = state_q;
      r_d     = r_q;
      cnt_d   = cnt_q;
      f_d     = f_q;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               r_d     = A;
               cnt_d   = Sh;
               f_d     = F;
               state_d = skip ? S_DONE : S_SHIFT;
            end
         end
         S_SHIFT: begin
            r_d   = step;
            cnt_d = cnt_q - N'(1);
            if (cnt_q == N'(1)) state_d = S_DONE;
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // DONE lasts one cycle, so Y loads only on the entering edge
   always_comb begin
      y_d    = (state_d == S_DONE) ? r_d : y_q;
      busy_d = (state_d != S_IDLE);
      done_d = (state_d == S_DONE);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         r_q     <= '0;
         cnt_q   <= '0;
         f_q     <= '0;
         y_q     <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         r_q     <= r_d;
         cnt_q   <= cnt_d;
         f_q     <= f_d;
         y_q     <= y_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   assign Y    = y_q;
   assign busy = busy_q;
   assign done = done_q;

endmodule

// File: doc/shifter_seq.md
# shifter_seq

Iterative, multi-cycle counterpart of the team's combinational barrel shifter. It uses the same operand width, shift amount and function codes, but moves one bit position per clock under a start/busy/done handshake. It serves datapaths that can spend `Sh` cycles per shift instead of a full barrel network. It sits behind the DE2 switch/LED test harness like the other Q-series blocks.

## Interface
Parameters:
- `N`, default 4: shift-amount width; data width is 2**N (16 bits by default).

Ports:
- `clk`, input, 1: single clock, rising edge.
- `rst_n`, input, 1: reset, synchronous, active-low.
- `start`, input, 1: request a new operation; sampled only in IDLE.
- `A`, input, 2**N: operand, captured at the start edge.
- `Sh`, input, N: shift amount 0..2**N-1, captured at the start edge.
- `F`, input, 2: function code, captured at the start edge.
  - 0 = logical left.
  - 1 = logical right.
  - 2 = pass (or rotate-left; see Configuration).
  - 3 = arithmetic right.
- `Y`, output, 2**N: result register; holds the last completed result.
- `busy`, output, 1: high whenever state is not IDLE.
- `done`, output, 1: one-cycle pulse; `Y` is valid in that cycle and stays valid afterwards.

## Operation
- State machine states:
  - IDLE: waits for `start`.
  - SHIFT: shifts one position per cycle.
  - DONE: one-cycle completion state.
- Internal registers: working register `R` (2**N bits), down-counter `cnt` (N bits), latched code `f`.
- IDLE with `start`=1 at a clock edge:
  - Load `R`=A, `cnt`=Sh, `f`=F.
  - If Sh==0, or if F==2 in pass mode, go to DONE.
  - Otherwise go to SHIFT.
- IDLE with `start`=0: state is unchanged.
- SHIFT, at each edge, `R` moves one position according to `f`:
  - Code 0: shift left, fill bit 0 with 0.
  - Code 1: shift right, fill the MSB with 0.
  - Code 3: shift right, fill the MSB with the current MSB (sign).
  - Code 2 with the rotate macro on: rotate left, old MSB into bit 0.
- SHIFT counter: `cnt` decrements on every shift; when `cnt`==1 before the edge, go to DONE.
- DONE: `Y` is loaded with `R`, `done`=1 and `busy`=1; the next edge returns to IDLE.
- `start` while busy (SHIFT or DONE) is ignored and not queued; operand changes while busy have no effect.
- Final result equals the combinational shifter for the same A/Sh/F.
  - Shift of 2**N-1 is legal; SRL/SLL of a single set bit leave one bit.
  - SRA of a negative operand fills with ones.

## Timing
- Reset (`rst_n`=0 at an edge): state = IDLE, `Y`=0, `done`=0, `busy`=0, `R`=0, `cnt`=0.
- Reset asserted mid-operation aborts it: no `done` pulse and `Y` is cleared.
- Number the start edge as edge 0.
  - DONE is entered after edge max(Sh,1) for shifting ops.
  - DONE is entered after edge 0 for Sh==0, or for pass mode.
- `done` is high for the cycle after that edge; `Y` updates at the same edge. Latency is Sh+1 cycles, and 1 cycle for Sh==0 or pass.
- `busy` rises the cycle after the start edge and falls after the DONE cycle. Earliest back-to-back start: the cycle after `done`.
- Outputs `Y`, `busy` and `done` are registered; there is no combinational path from inputs to outputs.

## Configuration
- `SHIFTER_ROTATE_EN` defined: F==2 is rotate-left by Sh and uses Sh+1 cycles like the other ops (Sh==0 completes in 1 cycle).
- `SHIFTER_ROTATE_EN` undefined: F==2 is pass; `Y`=A, completing in 1 cycle regardless of Sh.

## Test plan
- Reset: hold `rst_n`=0 for 2 cycles, then release -> `Y`=16'h0000, `busy`=0, `done`=0.
- Logical left: A=16'h00B6, Sh=4, F=0, pulse `start` -> `done` after edge 4, `Y`=16'h0B60, `busy` high for exactly 5 cycles.
- Arithmetic and logical right:
  - A=16'h80B6, Sh=3, F=3 -> `Y`=16'hF016.
  - A=16'h80B6, Sh=15, F=1 -> `Y`=16'h0001 after 16 cycles.
- Zero shift, then ignored start: A=16'h1234, Sh=0, F=1 -> `done` after edge 0 with `Y`=16'h1234. Then start a Sh=8 operation and assert `start` again with new operands mid-SHIFT -> second request ignored, result from the first operands only.
- F==2 in both builds: A=16'h80B6, Sh=4, F=2.
  - With `SHIFTER_ROTATE_EN`: `Y`=16'h0B68 after 5 cycles.
  - Without it: `Y`=16'h80B6 after 1 cycle.
- Mid-operation reset: A=16'h00B6, Sh=10, F=0; assert `rst_n`=0 at edge 5 -> no `done` pulse, `Y`=0, IDLE. A following start completes normally.
